// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two
//            requesters. The winner's operands go to an issue register that
//            drives the ALU. The ALU result is captured one edge later into
//            that requester's response buffer, so the fixed latency is 2 cycles.
// Options  : define ALU_ARB_STATS_EN to add saturating grant/conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int STAT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // requester 0
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_op1,
  input  logic [DATA_W-1:0] i_req0_op2,
  input  logic [CTRL_W-1:0] i_req0_ctrl,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [DATA_W-1:0] o_rsp0_result,
  output logic              o_rsp0_zf,
  // requester 1
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_op1,
  input  logic [DATA_W-1:0] i_req1_op2,
  input  logic [CTRL_W-1:0] i_req1_ctrl,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp1_result,
  output logic              o_rsp1_zf,
`ifdef ALU_ARB_STATS_EN
  // statistics
  input  logic              i_stat_clr,
  output logic [STAT_W-1:0] o_stat_grant0,
  output logic [STAT_W-1:0] o_stat_grant1,
  output logic [STAT_W-1:0] o_stat_conflict,
`endif
  // shared ALU
  output logic [DATA_W-1:0] o_alu_op1,
  output logic [DATA_W-1:0] o_alu_op2,
  output logic [CTRL_W-1:0] o_alu_control,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_zf
);

  // Issue stage
  logic              issue_valid;
  logic              issue_owner;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;
  logic [CTRL_W-1:0] issue_ctrl;
  logic              rr_ptr;

  // Response buffers
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_zf;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_zf;

  // Arbitration terms
  logic pend0;
  logic pend1;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // Eligibility and round-robin grant; a requester with an op in flight, or an
  // undrained result, must sit out so its buffer is free when capture happens.
  always_comb begin
    pend0  = (issue_valid && !issue_owner) || (rsp0_valid && !i_rsp0_ready);
    pend1  = (issue_valid &&  issue_owner) || (rsp1_valid && !i_rsp1_ready);
    elig0  = i_req0_valid && !pend0;
    elig1  = i_req1_valid && !pend1;
    grant0 = 1'b0;
    grant1 = 1'b0;
    // Readies are forced low while reset is held.
    if (i_rst_n) begin
      if (!rr_ptr) begin
        if (elig0)      grant0 = 1'b1;
        else if (elig1) grant1 = 1'b1;
      end else begin
        if (elig1)      grant1 = 1'b1;
        else if (elig0) grant0 = 1'b1;
      end
    end
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  // Issue register: load the winner, otherwise go idle; pointer passes to the
  // other requester after every grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      issue_valid <= 1'b0;
      issue_owner <= 1'b0;
      issue_op1   <= '0;
      issue_op2   <= '0;
      issue_ctrl  <= '0;
      rr_ptr      <= 1'b0;
    end else if (grant0) begin
      issue_valid <= 1'b1;
      issue_owner <= 1'b0;
      issue_op1   <= i_req0_op1;
      issue_op2   <= i_req0_op2;
      issue_ctrl  <= i_req0_ctrl;
      rr_ptr      <= 1'b1;
    end else if (grant1) begin
      issue_valid <= 1'b1;
      issue_owner <= 1'b1;
      issue_op1   <= i_req1_op1;
      issue_op2   <= i_req1_op2;
      issue_ctrl  <= i_req1_ctrl;
      rr_ptr      <= 1'b0;
    end else begin
      issue_valid <= 1'b0;
    end
  end

  // The ALU sees zeros whenever nothing is issued.
  assign o_alu_op1     = issue_valid ? issue_op1  : '0;
  assign o_alu_op2     = issue_valid ? issue_op2  : '0;
  assign o_alu_control = issue_valid ? issue_ctrl : '0;

  // Requester 0 response buffer: a new capture takes priority over a drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zf     <= 1'b0;
    end else if (issue_valid && !issue_owner) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= i_alu_result;
      rsp0_zf     <= i_alu_zf;
    end else if (rsp0_valid && i_rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  // Requester 1 response buffer: a new capture takes priority over a drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zf     <= 1'b0;
    end else if (issue_valid && issue_owner) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= i_alu_result;
      rsp1_zf     <= i_alu_zf;
    end else if (rsp1_valid && i_rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

  assign o_rsp0_valid  = rsp0_valid;
  assign o_rsp0_result = rsp0_result;
  assign o_rsp0_zf     = rsp0_zf;
  assign o_rsp1_valid  = rsp1_valid;
  assign o_rsp1_result = rsp1_result;
  assign o_rsp1_zf     = rsp1_zf;

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] stat_grant0;
  logic [STAT_W-1:0] stat_grant1;
  logic [STAT_W-1:0] stat_conflict;

  // Saturating event counters; clear wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else if (i_stat_clr) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant0 && !(&stat_grant0))           stat_grant0   <= stat_grant0 + 1'b1;
      if (grant1 && !(&stat_grant1))           stat_grant1   <= stat_grant1 + 1'b1;
      if (elig0 && elig1 && !(&stat_conflict)) stat_conflict <= stat_conflict + 1'b1;
    end
  end

  assign o_stat_grant0   = stat_grant0;
  assign o_stat_grant1   = stat_grant1;
  assign o_stat_conflict = stat_conflict;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter with a behavioural team ALU.
//            Define ALU_ARB_STATS_EN to also exercise the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
`ifdef ALU_ARB_STATS_EN
  localparam int STAT_W = 4;
`else
  localparam int STAT_W = 16;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic              rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp0_result, rsp1_result;
  logic              rsp0_zf, rsp1_zf;
  logic [DATA_W-1:0] alu_op1, alu_op2, alu_result;
  logic [CTRL_W-1:0] alu_control;
  logic              alu_zf;
`ifdef ALU_ARB_STATS_EN
  logic              stat_clr;
  logic [STAT_W-1:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic        zf;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          grant_log[$];
  int          cyc = 0;
  int          hs1_cnt = 0;
  logic [31:0] last_res0 = '0, last_res1 = '0;
  logic        last_zf0 = 1'b0, last_zf1 = 1'b0;
  logic        rsp0_new = 1'b1, rsp1_new = 1'b1;
  logic        prev_hs0 = 1'b0, prev_hs1 = 1'b0;
  logic [31:0] prev_op1 = '0, prev_op2 = '0;
  logic [3:0]  prev_ctrl = '0;

  // Behavioural model of the team ALU (undefined codes give 0).
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op1, alu_op2, alu_control);
  assign alu_zf     = (alu_result == 32'd0);

  alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STAT_W(STAT_W)) dut (
    .i_clk(clk),               .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_op1(req0_op1),     .i_req0_op2(req0_op2),     .i_req0_ctrl(req0_ctrl),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready),
    .o_rsp0_result(rsp0_result), .o_rsp0_zf(rsp0_zf),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_op1(req1_op1),     .i_req1_op2(req1_op2),     .i_req1_ctrl(req1_ctrl),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready),
    .o_rsp1_result(rsp1_result), .o_rsp1_zf(rsp1_zf),
`ifdef ALU_ARB_STATS_EN
    .i_stat_clr(stat_clr),     .o_stat_grant0(stat_grant0),
    .o_stat_grant1(stat_grant1), .o_stat_conflict(stat_conflict),
`endif
    .o_alu_op1(alu_op1),       .o_alu_op2(alu_op2),       .o_alu_control(alu_control),
    .i_alu_result(alu_result), .i_alu_zf(alu_zf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

`ifdef ALU_ARB_STATS_EN
  logic [3:0] m_g0 = '0, m_g1 = '0, m_cf = '0;
`endif

  // Monitor: sample at the falling edge, score responses, record handshakes.
  always @(negedge clk) begin
    logic pend0, pend1, elig0, elig1;
    cyc++;
    if (!rst_n) begin
      q0.delete(); q1.delete(); grant_log.delete();
      rsp0_new = 1'b1; rsp1_new = 1'b1;
      prev_hs0 = 1'b0; prev_hs1 = 1'b0;
`ifdef ALU_ARB_STATS_EN
      m_g0 = '0; m_g1 = '0; m_cf = '0;
`endif
    end else begin
      // ALU drive follows the previous handshake, zeros otherwise
      if (prev_hs0 || prev_hs1) begin
        check("alu_op1", alu_op1, prev_op1);
        check("alu_op2", alu_op2, prev_op2);
        check("alu_ctrl", alu_control, prev_ctrl);
      end else begin
        check("alu_idle_op1", alu_op1, 0);
        check("alu_idle_ctrl", alu_control, 0);
      end
      if (rsp0_valid) begin
        check("rsp0_expected", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          if (rsp0_new) check("rsp0_latency", cyc, q0[0].cyc + 2);
          check("rsp0_result", rsp0_result, q0[0].res);
          check("rsp0_zf", rsp0_zf, q0[0].zf);
          last_res0 = rsp0_result; last_zf0 = rsp0_zf;
          if (rsp0_ready) void'(q0.pop_front());
        end
      end
      if (rsp1_valid) begin
        check("rsp1_expected", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          if (rsp1_new) check("rsp1_latency", cyc, q1[0].cyc + 2);
          check("rsp1_result", rsp1_result, q1[0].res);
          check("rsp1_zf", rsp1_zf, q1[0].zf);
          last_res1 = rsp1_result; last_zf1 = rsp1_zf;
          if (rsp1_ready) void'(q1.pop_front());
        end
      end
      rsp0_new = !rsp0_valid || rsp0_ready;
      rsp1_new = !rsp1_valid || rsp1_ready;
      check("ready_onehot", req0_ready && req1_ready, 0);
      pend0 = prev_hs0 || (rsp0_valid && !rsp0_ready);
      pend1 = prev_hs1 || (rsp1_valid && !rsp1_ready);
      elig0 = req0_valid && !pend0;
      elig1 = req1_valid && !pend1;
`ifdef ALU_ARB_STATS_EN
      check("stat_grant0", stat_grant0, m_g0);
      check("stat_grant1", stat_grant1, m_g1);
      check("stat_conflict", stat_conflict, m_cf);
      if (stat_clr) begin
        m_g0 = '0; m_g1 = '0; m_cf = '0;
      end else begin
        if (req0_valid && req0_ready && m_g0 != 4'hF) m_g0++;
        if (req1_valid && req1_ready && m_g1 != 4'hF) m_g1++;
        if (elig0 && elig1 && m_cf != 4'hF) m_cf++;
      end
`else
      if (elig0 && elig1) check("grant_when_contended", req0_ready || req1_ready, 1);
`endif
      prev_hs0 = req0_valid && req0_ready;
      prev_hs1 = req1_valid && req1_ready;
      if (prev_hs0) begin
        q0.push_back('{cyc, alu_f(req0_op1, req0_op2, req0_ctrl),
                       alu_f(req0_op1, req0_op2, req0_ctrl) == 0});
        grant_log.push_back(0);
        prev_op1 = req0_op1; prev_op2 = req0_op2; prev_ctrl = req0_ctrl;
      end
      if (prev_hs1) begin
        q1.push_back('{cyc, alu_f(req1_op1, req1_op2, req1_ctrl),
                       alu_f(req1_op1, req1_op2, req1_ctrl) == 0});
        grant_log.push_back(1);
        hs1_cnt++;
        prev_op1 = req1_op1; prev_op2 = req1_op2; prev_ctrl = req1_ctrl;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op1 = '0; req0_op2 = '0; req0_ctrl = '0;
    req1_op1 = '0; req1_op2 = '0; req1_ctrl = '0;
`ifdef ALU_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
    req0_valid = v; req0_op1 = a; req0_op2 = b; req0_ctrl = c;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
    req1_valid = v; req1_op1 = a; req1_op2 = b; req1_ctrl = c;
  endtask

  task automatic settle_and_drain(input string tag);
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (6) @(negedge clk);
    check({tag, "_q0_empty"}, q0.size(), 0);
    check({tag, "_q1_empty"}, q1.size(), 0);
    step();
  endtask

  logic [3:0] ctrl_set [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1101};

  initial begin
    int h1;
    int n;
    // ---- reset state (valids high to show readies stay low) ----
    do_reset();
    rst_n = 1'b0; req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp0_result", rsp0_result, 0);
    check("rst_alu_op1", alu_op1, 0);

    // ---- single op: ADD 5+7 ----
    do_reset();
    drive0(1, 5, 7, 4'b0010); rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    step(); req0_valid = 0;
    @(negedge clk);
    check("t1_rsp0_early", rsp0_valid, 0);
    @(negedge clk);
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp0_result", rsp0_result, 12);
    check("t1_rsp0_zf", rsp0_zf, 0);
    settle_and_drain("t1");

    // ---- contention from reset ----
    do_reset();
    drive0(1, 9, 9, 4'b0110); drive1(1, 32'hF0, 32'h0F, 4'b0001);
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (8) step();
    settle_and_drain("t2");
    check("t2_grants", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) begin
      check("t2_grant_a", grant_log[0], 0);
      check("t2_grant_b", grant_log[1], 1);
      check("t2_grant_c", grant_log[2], 0);
      check("t2_grant_d", grant_log[3], 1);
    end
    check("t2_rsp0_result", last_res0, 0);
    check("t2_rsp0_zf", last_zf0, 1);
    check("t2_rsp1_result", last_res1, 32'hFF);
    check("t2_rsp1_zf", last_zf1, 0);

    // ---- backpressure on requester 0 ----
    do_reset();
    drive0(1, 1, 1, 4'b0010); drive1(1, 32'h12, 32'h40, 4'b0001);
    rsp0_ready = 0; rsp1_ready = 1;
    @(negedge clk);
    check("t3_ready0_first", req0_ready, 1);
    step(); drive0(1, 3, 4, 4'b0010);
    n = 0;
    @(negedge clk);
    while (!rsp0_valid && n < 10) begin @(negedge clk); n++; end
    check("t3_rsp0_arrives", rsp0_valid, 1);
    h1 = hs1_cnt;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", rsp0_valid, 1);
      check("t3_hold_result", rsp0_result, 2);
      check("t3_hold_ready0", req0_ready, 0);
      @(negedge clk);
    end
    check("t3_req1_progress", (hs1_cnt - h1) >= 2, 1);
    step(); req1_valid = 0;
    step(); rsp0_ready = 1;
    @(negedge clk);
    check("t3_drain_regrant", req0_ready, 1);
    check("t3_drain_result", rsp0_result, 2);
    step(); req0_valid = 0;
    settle_and_drain("t3");
    check("t3_second_result", last_res0, 7);

    // ---- single requester streaming: SLT 3<4 ----
    do_reset();
    drive1(1, 3, 4, 4'b0111); rsp1_ready = 1; rsp0_ready = 1;
    n = 0;
    @(negedge clk);
    while (!req1_ready && n < 10) begin @(negedge clk); n++; end
    check("t4_first_grant", req1_ready, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("t4_ready1_pattern", req1_ready, (i % 2) == 0);
    end
    settle_and_drain("t4");
    check("t4_result", last_res1, 1);

    // ---- asynchronous reset with an op in flight ----
    do_reset();
    drive0(1, 5, 5, 4'b0010); rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    check("t5_ready0", req0_ready, 1);
    step(); req0_valid = 0;
    #2;
    check("t5_inflight", alu_op1, 5);
    rst_n = 1'b0;
    drive0(1, 8, 3, 4'b0110); drive1(1, 32'hC, 32'hA, 4'b0000);
    #1;
    check("t5_rst_ready0", req0_ready, 0);
    check("t5_rst_ready1", req1_ready, 0);
    check("t5_rst_rsp0", rsp0_valid, 0);
    check("t5_rst_alu_op1", alu_op1, 0);
    check("t5_rst_alu_ctrl", alu_control, 0);
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ptr_ready0", req0_ready, 1);
    check("t5_ptr_ready1", req1_ready, 0);
    step(); step();
    settle_and_drain("t5");
    check("t5_result0", last_res0, 5);
    check("t5_result1", last_res1, 8);

    // ---- random mixed traffic ----
    do_reset();
    for (int i = 0; i < 120; i++) begin
      drive0($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 40),
             ctrl_set[$urandom_range(0, 5)]);
      drive1($urandom_range(0, 3) != 0, $urandom_range(0, 40), $urandom,
             ctrl_set[$urandom_range(0, 5)]);
      rsp0_ready = $urandom_range(0, 3) != 0;
      rsp1_ready = $urandom_range(0, 2) != 0;
      step();
    end
    settle_and_drain("t6");

`ifdef ALU_ARB_STATS_EN
    // ---- statistics: contention, saturation, clear ----
    do_reset();
    drive0(1, 2, 3, 4'b0010); drive1(1, 4, 1, 4'b0110);
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (10) step();
    @(negedge clk);
    check("s_conflict_10", stat_conflict, 1);
    check("s_grant0_10", stat_grant0, 5);
    check("s_grant1_10", stat_grant1, 5);
    step();
    repeat (40) step();
    @(negedge clk);
    check("s_grant0_sat", stat_grant0, 15);
    check("s_grant1_sat", stat_grant1, 15);
    step(); stat_clr = 1;
    step(); stat_clr = 0;
    #1;
    check("s_clr_grant0", stat_grant0, 0);
    check("s_clr_grant1", stat_grant1, 0);
    check("s_clr_conflict", stat_conflict, 0);
    settle_and_drain("s");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
